// File: rtl/collision_engine.sv
// collision_engine: one shared circle-overlap engine that tests the player against N_OBJ object channels once per frame.
// Build macro SPRITE_COOLDOWN_EN adds a per-channel cooldown of COOL_FR completed scans after each hit.
module collision_engine #(
   parameter int               N_OBJ     = 5,
   parameter int               OBJ_R     = 8,
   parameter logic [N_OBJ-1:0] FOOD_MASK = N_OBJ'(5'b10000),
   parameter int               SCORE_W   = 12,
   parameter int               COOL_FR   = 30
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  frame_tick,
   input  logic                  run,
   input  logic                  clear,
   input  logic [9:0]            px,
   input  logic [9:0]            py,
   input  logic [5:0]            pr,
   input  logic [10*N_OBJ-1:0]   obj_x,
   input  logic [10*N_OBJ-1:0]   obj_y,
   output logic [N_OBJ-1:0]      hit,
   output logic                  hit_enemy,
   output logic [SCORE_W-1:0]    score,
   output logic                  busy,
   output logic                  overrun
);

   localparam int               IW    = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
   localparam logic [IW-1:0]    LAST  = IW'(N_OBJ - 1);
   localparam logic [6:0]       OBJR7 = 7'(OBJ_R);
   localparam int               SUM_W = SCORE_W + 5;
   localparam logic [SUM_W-1:0] SAT   = SUM_W'({SCORE_W{1'b1}});

   if (N_OBJ < 1 || N_OBJ > 16) begin : gBadNObj
      $error("collision_engine: N_OBJ must be 1..16");
   end
   if (OBJ_R < 0 || OBJ_R > 63) begin : gBadObjR
      $error("collision_engine: OBJ_R must be 0..63");
   end
   if (COOL_FR < 0) begin : gBadCool
      $error("collision_engine: COOL_FR must be non-negative");
   end

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [9:0]         px_q, px_d;
   logic [9:0]         py_q, py_d;
   logic [5:0]         pr_q, pr_d;
   logic [N_OBJ-1:0]   latch_q, latch_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic               overrun_q, overrun_d;

   logic [9:0]         ox, oy, dx, dy;
   logic [19:0]        dx2, dy2;
   logic [20:0]        d2;
   logic [6:0]         rs;
   logic [13:0]        lim;
   logic               closeNow;
   logic [N_OBJ-1:0]   coolBusy;
   logic [N_OBJ-1:0]   foodHits;
   logic [4:0]         foodCnt;
   logic [SUM_W-1:0]   scoreSum;
   logic               startScan;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         px_q      <= '0;
         py_q      <= '0;
         pr_q      <= '0;
         latch_q   <= '0;
         score_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         px_q      <= px_d;
         py_q      <= py_d;
         pr_q      <= pr_d;
         latch_q   <= latch_d;
         score_q   <= score_d;
         overrun_q <= overrun_d;
      end
   end

   // clear and a dropped run both abandon a scan in progress.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (frame_tick && run && !clear) state_d = SCAN;
         SCAN: begin
            if (clear || !run)        state_d = IDLE;
            else if (idx_q == LAST)   state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      hit       = (state_q == DONE) ? latch_q : '0;
      hit_enemy = |(hit & ~FOOD_MASK);
      busy      = (state_q == SCAN);
      score     = score_q;
      overrun   = overrun_q;
   end

   always_comb begin
      ox = '0;
      oy = '0;
      for (int i = 0; i < N_OBJ; i++) begin
         if (idx_q == IW'(i)) begin
            ox = obj_x[10*i +: 10];
            oy = obj_y[10*i +: 10];
         end
      end
   end

   // Full-width arithmetic so no distance can wrap into a false hit.
   always_comb begin
      dx       = (px_q >= ox) ? (px_q - ox) : (ox - px_q);
      dy       = (py_q >= oy) ? (py_q - oy) : (oy - py_q);
      dx2      = 20'(dx) * 20'(dx);
      dy2      = 20'(dy) * 20'(dy);
      d2       = 21'(dx2) + 21'(dy2);
      rs       = 7'(pr_q) + OBJR7;
      lim      = 14'(rs) * 14'(rs);
      closeNow = (d2 < 21'(lim));
   end

   always_comb begin
      startScan = (state_q == IDLE) && (state_d == SCAN);
      idx_d     = (state_q == SCAN && state_d == SCAN) ? idx_q + IW'(1) : '0;
      px_d      = startScan ? px : px_q;
      py_d      = startScan ? py : py_q;
      pr_d      = startScan ? pr : pr_q;
   end

   // The latch survives only SCAN -> DONE; an aborted scan leaves nothing behind.
   always_comb begin
      latch_d = latch_q;
      unique case (state_q)
         IDLE: latch_d = '0;
         SCAN: begin
            if (state_d == IDLE) begin
               latch_d = '0;
            end else begin
               for (int i = 0; i < N_OBJ; i++) begin
                  if (idx_q == IW'(i) && closeNow && !coolBusy[i]) latch_d[i] = 1'b1;
               end
            end
         end
         default: latch_d = latch_q;
      endcase
   end

   always_comb begin
      foodHits = latch_q & FOOD_MASK;
      foodCnt  = '0;
      for (int i = 0; i < N_OBJ; i++) begin
         foodCnt = foodCnt + 5'(foodHits[i]);
      end
      scoreSum = SUM_W'(score_q) + SUM_W'(foodCnt);
      score_d  = score_q;
      if (clear) begin
         score_d = '0;
      end else if (state_q == DONE) begin
         score_d = (scoreSum > SAT) ? {SCORE_W{1'b1}} : scoreSum[SCORE_W-1:0];
      end
   end

   always_comb begin
      overrun_d = overrun_q;
      if (clear)                              overrun_d = 1'b0;
      else if (state_q == SCAN && frame_tick) overrun_d = 1'b1;
   end

`ifdef SPRITE_COOLDOWN_EN
   localparam int CW = (COOL_FR > 0) ? $clog2(COOL_FR + 1) : 1;

   logic [N_OBJ-1:0][CW-1:0] cool_q, cool_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cool_q <= '0;
      else          cool_q <= cool_d;
   end

   // Counters tick only on completed scans, reloading on a fresh hit.
   always_comb begin
      cool_d   = cool_q;
      coolBusy = '0;
      for (int i = 0; i < N_OBJ; i++) begin
         coolBusy[i] = (cool_q[i] != '0);
         if (clear) begin
            cool_d[i] = '0;
         end else if (state_q == DONE) begin
            if (latch_q[i])             cool_d[i] = CW'(COOL_FR);
            else if (cool_q[i] != '0)   cool_d[i] = cool_q[i] - CW'(1);
         end
      end
   end
`else
   always_comb coolBusy = '0;
`endif

endmodule
